i2c_slave_ctrl: RTL

// - Synthesizable I2C target (slave). It is the bus-side counterpart of i2c_master.
// - Runs on clk_sys and oversamples raw SCL/SDA. Supports 7-bit addressing, multi-byte write and read, and repeated START.
// - Pushes received bytes to a user RX sink and pops read bytes from a user TX FIFO. No clock stretching.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_bus_filter.sv | 55 +++++
 rtl/i2c_slave_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// ============================================================================
// Module : i2c_pkg
// Brief  : Shared constants and FSM encoding for the I2C target controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

  localparam int   C_I2C_ADDR_W = 7;
  localparam int   C_I2C_BYTE_W = 8;
  localparam logic C_I2C_ACK    = 1'b0;
  localparam logic C_I2C_NACK   = 1'b1;

  typedef logic [3:0] t_i2c_slv_state;

  localparam t_i2c_slv_state S_IDLE      = 4'd0;
  localparam t_i2c_slv_state S_ADDR      = 4'd1;
  localparam t_i2c_slv_state S_ADDR_ACK  = 4'd2;
  localparam t_i2c_slv_state S_WR_DATA   = 4'd3;
  localparam t_i2c_slv_state S_WR_ACK    = 4'd4;
  localparam t_i2c_slv_state S_RD_LOAD   = 4'd5;
  localparam t_i2c_slv_state S_RD_DATA   = 4'd6;
  localparam t_i2c_slv_state S_RD_ACK    = 4'd7;
  localparam t_i2c_slv_state S_WAIT_STOP = 4'd8;

endpackage

`default_nettype wire

// File: rtl/i2c_bus_filter.sv
// ============================================================================
// Module : i2c_bus_filter
// Brief  : Synchronizer, glitch filter and edge pulses for one raw bus line.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_bus_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int C_CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [C_CNT_W-1:0]     r_cnt;
  logic                   w_sample;

  assign w_sample = r_sync[SYNC_STAGES-1];

  // Idle bus is pulled up, so reset to 1 to avoid a spurious edge on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_cnt  <= '0;
      level  <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (w_sample == level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_W'(FILTER_LEN - 1)) begin
        level <= w_sample;
        r_cnt <= '0;
        rise  <= w_sample;
        fall  <= ~w_sample;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_slave_ctrl.sv
// ============================================================================
// Module : i2c_slave_ctrl
// Brief  : Oversampling I2C target: 7-bit address, multi-byte read/write, Sr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter logic [C_I2C_ADDR_W-1:0] G_SLAVE_ADDR  = 7'h50,
  parameter int                      G_SYNC_STAGES = 2,
  parameter int                      G_FILTER_LEN  = 3,
  parameter int                      G_HOLD_CYCLES = 4
) (
  input  logic       clk_sys,
  input  logic       rst_n_sys,
  input  logic       sclk_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_en,
  output logic [7:0] wdata,
  output logic       wdata_valid,
  input  logic       rx_ready,
  output logic       rd_en_tx,
  input  logic [7:0] rdata_tx,
  input  logic       tx_empty,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det,
  output logic       addressed,
  output logic       rw,
  output logic       nack_rx,
  output logic       tx_underrun,
  output logic       wr_overflow
);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_start, w_stop, w_drive;
  logic [C_I2C_BYTE_W-1:0] w_byte;

  t_i2c_slv_state          r_state;
  logic [3:0]              r_bit_cnt;
  logic [C_I2C_BYTE_W-1:0] r_shift;
  logic [7:0]              r_hold_cnt;
  logic                    r_hold_pend;
  logic                    r_rd_en, r_rd_en_q;
  logic                    r_sda_en, r_wdata_valid, r_busy, r_start_det, r_stop_det;
  logic                    r_addressed, r_rw, r_nack_rx, r_underrun, r_overflow;
  logic [C_I2C_BYTE_W-1:0] r_wdata;

  i2c_bus_filter #(.SYNC_STAGES(G_SYNC_STAGES), .FILTER_LEN(G_FILTER_LEN)) u_scl_filt (
    .clk(clk_sys), .rst_n(rst_n_sys), .raw(sclk_in),
    .level(w_scl_lvl), .rise(w_scl_rise), .fall(w_scl_fall)
  );

  i2c_bus_filter #(.SYNC_STAGES(G_SYNC_STAGES), .FILTER_LEN(G_FILTER_LEN)) u_sda_filt (
    .clk(clk_sys), .rst_n(rst_n_sys), .raw(sda_in),
    .level(w_sda_lvl), .rise(w_sda_rise), .fall(w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl_lvl;
  assign w_stop  = w_sda_rise & w_scl_lvl;
  assign w_byte  = {r_shift[C_I2C_BYTE_W-2:0], w_sda_lvl};

  // Level applied to sda_en when the hold delay after SCL fall expires.
  always_comb begin
    w_drive = 1'b0;
    case (r_state)
      S_ADDR_ACK, S_WR_ACK: w_drive = (r_bit_cnt == 4'd8);
      S_RD_DATA:            w_drive = ~r_shift[C_I2C_BYTE_W-1];
      default:              w_drive = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n_sys) begin
    if (!rst_n_sys) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= 4'd0;
      r_shift       <= '0;
      r_hold_cnt    <= 8'd0;
      r_hold_pend   <= 1'b0;
      r_rd_en       <= 1'b0;
      r_rd_en_q     <= 1'b0;
      r_sda_en      <= 1'b0;
      r_wdata       <= '0;
      r_wdata_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_start_det   <= 1'b0;
      r_stop_det    <= 1'b0;
      r_addressed   <= 1'b0;
      r_rw          <= 1'b0;
      r_nack_rx     <= 1'b0;
      r_underrun    <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_wdata_valid <= 1'b0;
      r_start_det   <= 1'b0;
      r_stop_det    <= 1'b0;
      r_nack_rx     <= 1'b0;
      r_underrun    <= 1'b0;
      r_overflow    <= 1'b0;
      r_rd_en       <= 1'b0;
      r_rd_en_q     <= r_rd_en;
      if (w_start) begin
        r_state     <= S_ADDR;
        r_bit_cnt   <= 4'd0;
        r_busy      <= 1'b1;
        r_addressed <= 1'b0;
        r_start_det <= 1'b1;
        r_sda_en    <= 1'b0;
        r_hold_pend <= 1'b0;
      end else if (w_stop) begin
        r_state     <= S_IDLE;
        r_bit_cnt   <= 4'd0;
        r_busy      <= 1'b0;
        r_addressed <= 1'b0;
        r_stop_det  <= 1'b1;
        r_sda_en    <= 1'b0;
        r_hold_pend <= 1'b0;
      end else begin
        // Read data is not in the shift register until RD_LOAD completes.
        if (r_hold_pend) begin
          if (r_hold_cnt > 8'd1) begin
            r_hold_cnt <= r_hold_cnt - 8'd1;
          end else if (r_state != S_RD_LOAD) begin
            r_sda_en    <= w_drive;
            r_hold_pend <= 1'b0;
          end
        end
        if (w_scl_fall && r_state != S_IDLE) begin
          r_hold_cnt  <= 8'(G_HOLD_CYCLES - 1);
          r_hold_pend <= 1'b1;
        end
        if (w_scl_rise && r_state != S_IDLE && r_state != S_WAIT_STOP)
          r_bit_cnt <= (r_bit_cnt == 4'd8) ? 4'd0 : r_bit_cnt + 4'd1;

        case (r_state)
          S_ADDR: if (w_scl_rise) begin
            r_shift <= w_byte;
            if (r_bit_cnt == 4'd7) begin
              if (w_byte[7:1] == G_SLAVE_ADDR) begin
                r_state     <= S_ADDR_ACK;
                r_addressed <= 1'b1;
                r_rw        <= w_byte[0];
              end else begin
                r_state <= S_WAIT_STOP;
              end
            end
          end
          S_ADDR_ACK: if (w_scl_fall && r_bit_cnt == 4'd0) begin
            if (r_rw) begin
              r_state <= S_RD_LOAD;
              r_rd_en <= ~tx_empty;
            end else begin
              r_state <= S_WR_DATA;
            end
          end
          S_WR_DATA: if (w_scl_rise) begin
            r_shift <= w_byte;
            if (r_bit_cnt == 4'd7) begin
              if (rx_ready) begin
                r_wdata       <= w_byte;
                r_wdata_valid <= 1'b1;
                r_state       <= S_WR_ACK;
              end else begin
                r_overflow <= 1'b1;
                r_state    <= S_WAIT_STOP;
              end
            end
          end
          S_WR_ACK: if (w_scl_fall && r_bit_cnt == 4'd0) r_state <= S_WR_DATA;
          S_RD_LOAD: begin
            if (r_rd_en_q) begin
              r_shift <= rdata_tx;
              r_state <= S_RD_DATA;
            end else if (!r_rd_en) begin
              r_shift    <= 8'hFF;
              r_underrun <= 1'b1;
              r_state    <= S_RD_DATA;
            end
          end
          S_RD_DATA: if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) r_state <= S_RD_ACK;
            else                   r_shift <= {r_shift[C_I2C_BYTE_W-2:0], 1'b1};
          end
          S_RD_ACK: begin
            if (w_scl_rise && w_sda_lvl == C_I2C_NACK) begin
              r_nack_rx <= 1'b1;
              r_state   <= S_WAIT_STOP;
            end else if (w_scl_fall && r_bit_cnt == 4'd0) begin
              r_state <= S_RD_LOAD;
              r_rd_en <= ~tx_empty;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_out     = 1'b0;
  assign sda_en      = r_sda_en;
  assign wdata       = r_wdata;
  assign wdata_valid = r_wdata_valid;
  assign rd_en_tx    = r_rd_en;
  assign busy        = r_busy;
  assign start_det   = r_start_det;
  assign stop_det    = r_stop_det;
  assign addressed   = r_addressed;
  assign rw          = r_rw;
  assign nack_rx     = r_nack_rx;
  assign tx_underrun = r_underrun;
  assign wr_overflow = r_overflow;

endmodule

`default_nettype wire
